// File: rtl/Defines.sv
// Shared bus widths and UART register map used by the APB UART master and its users.
`ifndef APB_UART_DEFINES_SV
`define APB_UART_DEFINES_SV

`define DATA_WIDTH 32
`define ADDR_WIDTH 8

`define TRANS_DATA  8'h00
`define RECV_DATA   8'h04
`define BAUD_CONFIG 8'h08

`endif

// File: rtl/apb_uart_master.sv
// Two-requester APB master: round-robin grant, one transfer at a time, wait-state timeout.
`include "Defines.sv"

module apb_uart_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   r0_req,
  input  logic                   r0_write,
  input  logic [`ADDR_WIDTH-1:0] r0_addr,
  input  logic [`DATA_WIDTH-1:0] r0_wdata,
  output logic                   r0_done,
  output logic [`DATA_WIDTH-1:0] r0_rdata,
  output logic                   r0_err,
  input  logic                   r1_req,
  input  logic                   r1_write,
  input  logic [`ADDR_WIDTH-1:0] r1_addr,
  input  logic [`DATA_WIDTH-1:0] r1_wdata,
  output logic                   r1_done,
  output logic [`DATA_WIDTH-1:0] r1_rdata,
  output logic                   r1_err,
  output logic                   busy,
  output logic                   PSELx,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [`ADDR_WIDTH-1:0] PADDR,
  output logic [`DATA_WIDTH-1:0] PWDATA,
  input  logic [`DATA_WIDTH-1:0] PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic       ptr;
  logic       gnt_id;
  logic       grant;
  logic       gnt_sel;
  logic       complete;
  logic       abort;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  // A done pulse marks the turnaround cycle, so no grant is made while either is high.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gnt_sel  = ptr;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if ((r0_req || r1_req) && !(r0_done || r1_done)) begin
          grant    = 1'b1;
          gnt_sel  = (r0_req && r1_req) ? ptr : r1_req;
          state_nx = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          complete = 1'b1;
          state_nx = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
      ptr      <= 1'b0;
      gnt_id   <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      if (grant) begin
        wait_cnt <= '0;
        gnt_id   <= gnt_sel;
        ptr      <= ~gnt_sel;
        PWRITE   <= gnt_sel ? r1_write : r0_write;
        PADDR    <= gnt_sel ? r1_addr  : r0_addr;
        PWDATA   <= gnt_sel ? r1_wdata : r0_wdata;
      end else if (state == ACCESS && !PREADY) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (complete || abort) begin
        if (gnt_id) begin
          r1_done  <= 1'b1;
          r1_rdata <= (abort || PWRITE) ? '0 : PRDATA;
          r1_err   <= abort | PSLVERR;
        end else begin
          r0_done  <= 1'b1;
          r0_rdata <= (abort || PWRITE) ? '0 : PRDATA;
          r0_err   <= abort | PSLVERR;
        end
      end
    end
  end

  assign PSELx   = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_apb_uart_master.sv
// Self-checking bench for apb_uart_master: directed scenarios plus randomized transfers.
`include "Defines.sv"

module tb_apb_uart_master;

  localparam int DW      = `DATA_WIDTH;
  localparam int AW      = `ADDR_WIDTH;
  localparam int TIMEOUT = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          r0_req, r0_write, r1_req, r1_write;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_done, r0_err, r1_done, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          busy, PSELx, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_uart_master #(.TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .busy(busy), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int passed = 0;

  // Per-requester transfer plan and the last result each requester was told about.
  logic          p_write [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  int            p_waits [2];
  logic [DW-1:0] p_prdata[2];
  logic          p_slverr[2];
  logic [DW-1:0] last_rd [2];
  logic          last_err[2];
  int            rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic done_of(input int w);
    return (w == 0) ? r0_done : r1_done;
  endfunction
  function automatic logic [DW-1:0] rdata_of(input int w);
    return (w == 0) ? r0_rdata : r1_rdata;
  endfunction
  function automatic logic err_of(input int w);
    return (w == 0) ? r0_err : r1_err;
  endfunction

  task automatic set_req(input int w, input logic v);
    if (w == 0) r0_req = v; else r1_req = v;
  endtask

  task automatic reset_model();
    rr = 0;
    for (int i = 0; i < 2; i++) begin
      last_rd[i]  = '0;
      last_err[i] = 1'b0;
    end
  endtask

  task automatic rand_plan(input int w);
    p_write[w]  = 1'($urandom);
    p_addr[w]   = AW'($urandom);
    p_wdata[w]  = DW'($urandom);
    p_prdata[w] = DW'($urandom);
    p_slverr[w] = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 9))
      0:       p_waits[w] = TIMEOUT - 1;
      1:       p_waits[w] = TIMEOUT + 2;
      default: p_waits[w] = $urandom_range(0, 3);
    endcase
  endtask

  // Called at a negedge in an idle, non-turnaround cycle; serves every wanted requester.
  task automatic serve(input bit want0, input bit want1, input bit may_drop);
    bit            pend[2];
    int            w, o, n_acc;
    bit            aborted;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    pend[0] = want0;
    pend[1] = want1;
    r0_req = want0; r0_write = p_write[0]; r0_addr = p_addr[0]; r0_wdata = p_wdata[0];
    r1_req = want1; r1_write = p_write[1]; r1_addr = p_addr[1]; r1_wdata = p_wdata[1];
    while (pend[0] || pend[1]) begin
      w  = (pend[0] && pend[1]) ? rr : (pend[1] ? 1 : 0);
      o  = 1 - w;
      rr = o;
      @(negedge PCLK);
      chk("setup_psel", PSELx, 1'b1);
      chk("setup_penable", PENABLE, 1'b0);
      chk("setup_busy", busy, 1'b1);
      chk("setup_paddr", PADDR, p_addr[w]);
      chk("setup_pwrite", PWRITE, p_write[w]);
      chk("setup_pwdata", PWDATA, p_wdata[w]);
      // Requester inputs after the grant must have no effect.
      if (w == 0) begin r0_write = ~p_write[0]; r0_addr = ~p_addr[0]; r0_wdata = ~p_wdata[0]; end
      else        begin r1_write = ~p_write[1]; r1_addr = ~p_addr[1]; r1_wdata = ~p_wdata[1]; end
      if (may_drop && $urandom_range(0, 1) == 1) set_req(w, 1'b0);
      aborted = (p_waits[w] >= TIMEOUT);
      n_acc   = aborted ? TIMEOUT : p_waits[w] + 1;
      for (int i = 0; i < n_acc; i++) begin
        @(negedge PCLK);
        chk("access_psel", PSELx, 1'b1);
        chk("access_penable", PENABLE, 1'b1);
        chk("access_paddr", PADDR, p_addr[w]);
        chk("access_pwdata", PWDATA, p_wdata[w]);
        chk("access_done", done_of(w), 1'b0);
        PREADY  = (i >= p_waits[w]);
        PRDATA  = PREADY ? p_prdata[w] : DW'($urandom);
        PSLVERR = PREADY ? p_slverr[w] : 1'($urandom);
      end
      @(negedge PCLK);
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      exp_rd  = (aborted || p_write[w]) ? '0 : p_prdata[w];
      exp_err = aborted ? 1'b1 : p_slverr[w];
      chk("done_pulse", done_of(w), 1'b1);
      chk("other_done", done_of(o), 1'b0);
      chk("done_rdata", rdata_of(w), exp_rd);
      chk("done_err", err_of(w), exp_err);
      chk("other_rdata_held", rdata_of(o), last_rd[o]);
      chk("done_psel", PSELx, 1'b0);
      chk("done_busy", busy, 1'b0);
      last_rd[w]  = exp_rd;
      last_err[w] = exp_err;
      set_req(w, 1'b0);
      pend[w] = 0;
      @(negedge PCLK);
      chk("turn_done", done_of(w), 1'b0);
      chk("turn_psel", PSELx, 1'b0);
      chk("turn_rdata_held", rdata_of(w), last_rd[w]);
      chk("turn_err_held", err_of(w), last_err[w]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_psel"}, PSELx, 1'b0);
    chk({tag, "_penable"}, PENABLE, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pwrite"}, PWRITE, 1'b0);
    chk({tag, "_paddr"}, PADDR, '0);
    chk({tag, "_pwdata"}, PWDATA, '0);
    chk({tag, "_dones"}, {r0_done, r1_done}, 2'b00);
    chk({tag, "_rdata"}, {r0_rdata, r1_rdata}, '0);
    chk({tag, "_errs"}, {r0_err, r1_err}, 2'b00);
  endtask

  initial begin
    PRESETn = 1'b0;
    r0_req = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
    PRDATA = '0; PREADY = 0; PSLVERR = 0;
    reset_model();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Contention from reset: r0 first, then alternation.
    rand_plan(0); rand_plan(1); p_waits[0] = 0; p_waits[1] = 1;
    serve(1, 1, 0);
    rand_plan(0); rand_plan(1); p_waits[0] = 2; p_waits[1] = 0;
    serve(1, 1, 0);

    // Single write to baud_config, no wait states.
    p_write[0] = 1; p_addr[0] = `BAUD_CONFIG; p_wdata[0] = 'h2;
    p_waits[0] = 0; p_prdata[0] = 'h77; p_slverr[0] = 0;
    serve(1, 0, 0);

    // Read of recv_data with three wait states.
    p_write[1] = 0; p_addr[1] = `RECV_DATA; p_wdata[1] = 'h0;
    p_waits[1] = 3; p_prdata[1] = 'h5A; p_slverr[1] = 0;
    serve(0, 1, 0);

    // Timeout abort, then PREADY arriving on the last permitted cycle.
    p_write[0] = 0; p_addr[0] = `RECV_DATA; p_prdata[0] = 'hDEAD; p_slverr[0] = 0;
    p_waits[0] = TIMEOUT;
    serve(1, 0, 0);
    p_waits[0] = TIMEOUT - 1; p_prdata[0] = 'hBEEF;
    serve(1, 0, 0);

    // Slave error on a write, then a clean transfer.
    p_write[1] = 1; p_addr[1] = `TRANS_DATA; p_wdata[1] = 'h41; p_waits[1] = 0; p_slverr[1] = 1;
    serve(0, 1, 0);
    p_slverr[1] = 0; p_wdata[1] = 'h42;
    serve(0, 1, 0);

    // Reset in the middle of ACCESS abandons the transfer silently.
    r0_req = 1; r0_write = 0; r0_addr = `RECV_DATA; r0_wdata = '0;
    @(negedge PCLK);
    chk("pre_reset_setup", PSELx, 1'b1);
    @(negedge PCLK);
    chk("pre_reset_access", PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    check_all_zero("async_reset");
    r0_req = 0;
    repeat (2) begin
      @(negedge PCLK);
      chk("reset_no_done", {r0_done, r1_done}, 2'b00);
    end
    PRESETn = 1'b1;
    reset_model();
    @(negedge PCLK);
    chk("post_reset_idle", PSELx, 1'b0);
    rand_plan(1); p_waits[1] = 1;
    serve(0, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      rand_plan(0); rand_plan(1);
      serve(pat[0], pat[1], 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
